scrambler_lane_ctrl: RTL and testbench
======================================

// Module: scrambler_lane_ctrl
// PURPOSE
//  Per-lane scrambling controller for the Gen1/Gen2 8b/10b transmit path. Owns the
//  16-bit scrambler LFSR (x^16+x^5+x^4+x^3+1), sequences it from the symbol stream,
//  and XORs data bytes with the keystream. COM re-seeds the LFSR, SKP holds it, and
//  K symbols pass through unscrambled. Sits between the ordered-set/packet muxer and
//  the 8b/10b encoder, with a valid/ready handshake on both sides.
// PARAMETERS
//  SEED     16'hFFFF  LFSR value loaded on reset, on COM and while not ACTIVE
//  COM_SYM  8'hBC     K28.5 byte value; re-seeds the LFSR
//  SKP_SYM  8'h1C     K28.0 byte value; LFSR does not advance
// PORTS
//  pclk         in   1   lane clock; all state changes on posedge
//  reset        in   1   asynchronous, active-high reset
//  scramble_en  in   1   1 = scrambling enabled (inverse of the training "disable scrambling" bit)
//  in_valid     in   1   input symbol valid
//  in_ready     out  1   controller can accept a symbol this cycle
//  in_data      in   8   input symbol byte
//  in_k         in   1   1 = in_data is a K symbol
//  out_valid    out  1   output symbol valid
//  out_ready    in   1   encoder accepts the output symbol
//  out_data     out  8   scrambled (or bypassed) byte
//  out_k        out  1   K flag, delayed to align with out_data
//  locked       out  1   1 while state == ACTIVE
//  lfsr_state   out  16  current LFSR register, for debug and the verification bench
// BEHAVIOUR
//  - Reset values: out_valid=0, out_data=0, out_k=0, locked=0, lfsr=SEED, state=DIS.
//  - Handshake: accept = in_valid & in_ready. in_ready = ~out_valid | out_ready.
//    Output stage is a single register. When out_valid & ~out_ready, out_data and out_k
//    are held stable and no symbol is accepted.
//  - Latency: one accepted symbol appears on out_* on the next cycle. Sustained rate is
//    1 symbol/cycle while out_ready=1.
//  - Key: key[i] = lfsr[15-i] for i=0..7, taken from the LFSR value before the advance.
//    Advance = 8 serial LFSR shifts per symbol, computed in parallel within one cycle.
//  - FSM states: DIS, WAIT_COM, ACTIVE.
//    DIS: entered whenever scramble_en=0, from any state, effective the same cycle.
//      lfsr is forced to SEED. Accepted symbols pass through unchanged.
//    DIS->WAIT_COM: on the next clock edge with scramble_en=1. A symbol accepted in
//      the DIS cycle is still bypassed.
//    WAIT_COM: lfsr is held at SEED and symbols pass through unchanged.
//      On an accepted COM (in_k & in_data==COM_SYM), go to ACTIVE.
//    ACTIVE: all symbols are processed per the table below. Only scramble_en=0 or
//      reset leaves this state.
//  - Per accepted symbol in ACTIVE:
//    K and COM_SYM          -> out=in unchanged; lfsr<=SEED
//    K and SKP_SYM          -> out=in unchanged; lfsr unchanged
//    other K                -> out=in unchanged; lfsr advances
//    D                      -> out=in^key; lfsr advances
//  - No accept in a cycle: lfsr, state and the output register are unchanged
//    (except for the DIS forcing rule).
//  - Reset asserted mid-stream: all outputs return to their reset values immediately.
//    Any in-flight output symbol is dropped.
// TESTING
//  1 reset pulse, scramble_en=1 -> out_valid=0 and lfsr_state=16'hFFFF during reset;
//    locked=0 after release.
//  2 COM(K), then D 00 x4 -> out: BC(k=1), FF, 17, C0, 14; locked=1 from the cycle after COM.
//  3 COM, D00, SKP(K), D00, COM, D00 -> BC, FF, 1C(k), 17, BC, FF (SKP does not
//    advance the LFSR; COM re-seeds it).
//  4 Stream D00 x6 after COM, out_ready=0 for 3 cycles mid-stream -> out_data stable,
//    in_ready=0 while stalled; full key sequence FF,17,C0,14,B2,E7 delivered with no
//    loss or duplication.
//  5 Drop scramble_en mid-stream with in_valid=1 -> that symbol and later ones are
//    unscrambled; lfsr=FFFF; locked=0. Re-enable -> bypass continues until the next COM.
//  6 Assert reset while out_valid=1 and the stage is stalled -> out_valid=0 immediately;
//    after release, the first COM again yields key FF on the next D byte.

Source files
------------

// File: rtl/scrambler_lane_if.sv
// Symbol handshake bundle between the ordered-set muxer, the lane scrambler and the 8b/10b encoder.
interface scrambler_lane_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_k;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_k;

    modport master (
        output in_valid, in_data, in_k, out_ready,
        input  in_ready, out_valid, out_data, out_k
    );

    modport slave (
        input  in_valid, in_data, in_k, out_ready,
        output in_ready, out_valid, out_data, out_k
    );
endinterface

// File: rtl/scrambler_lane_ctrl.sv
// Per-lane Gen1/Gen2 scrambler: 16-bit LFSR (x^16+x^5+x^4+x^3+1) sequenced by the symbol
// stream, COM re-seeds, SKP holds, K symbols bypass; single-register output stage.
module scrambler_lane_ctrl #(
    parameter logic [15:0] SEED    = 16'hFFFF,
    parameter logic [7:0]  COM_SYM = 8'hBC,
    parameter logic [7:0]  SKP_SYM = 8'h1C
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              scramble_en,
    scrambler_lane_if.slave   lane,
    output logic              locked,
    output logic [15:0]       lfsr_state
);

    localparam logic [1:0] ST_DIS      = 2'd0;
    localparam logic [1:0] ST_WAIT_COM = 2'd1;
    localparam logic [1:0] ST_ACTIVE   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_k_q, out_k_d;

    logic        accept;
    logic        is_com;
    logic        is_skp;
    logic [7:0]  key;

    // Eight serial Galois shifts folded into one cycle.
    function automatic logic [15:0] lfsr_adv8(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 8; i++) begin
            r = {r[14:0], r[15]} ^ ({16{r[15]}} & 16'h0038);
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            key[i] = lfsr_q[15-i];
        end
    end

    assign lane.in_ready = ~out_valid_q | lane.out_ready;
    assign accept        = lane.in_valid & lane.in_ready;
    assign is_com        = lane.in_k & (lane.in_data == COM_SYM);
    assign is_skp        = lane.in_k & (lane.in_data == SKP_SYM);

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_k_d     = out_k_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = lane.in_data;
            out_k_d     = lane.in_k;
        end else if (lane.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (!scramble_en) begin
            state_d = ST_DIS;
            lfsr_d  = SEED;
        end else begin
            case (state_q)
                ST_DIS: begin
                    state_d = ST_WAIT_COM;
                    lfsr_d  = SEED;
                end
                ST_WAIT_COM: begin
                    lfsr_d = SEED;
                    if (accept && is_com) begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (accept) begin
                        if (is_com) begin
                            lfsr_d = SEED;
                        end else if (!is_skp) begin
                            lfsr_d = lfsr_adv8(lfsr_q);
                        end
                        if (!lane.in_k) begin
                            out_data_d = lane.in_data ^ key;
                        end
                    end
                end
                default: begin
                    state_d = ST_DIS;
                    lfsr_d  = SEED;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_DIS;
            lfsr_q      <= SEED;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_k_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_k_q     <= out_k_d;
        end
    end

    // Dropping scramble_en takes the lane out of ACTIVE in the same cycle.
    assign locked         = (state_q == ST_ACTIVE) & scramble_en;
    assign lfsr_state     = lfsr_q;
    assign lane.out_valid = out_valid_q;
    assign lane.out_data  = out_data_q;
    assign lane.out_k     = out_k_q;

endmodule

// File: tb/tb_scrambler_lane_ctrl.sv
// Directed bench for scrambler_lane_ctrl: vector table for the main stream plus
// hand-written sequences for disable/re-enable and reset during a stall.
module tb_scrambler_lane_ctrl;

    logic        pclk;
    logic        reset;
    logic        scramble_en;
    logic        locked;
    logic [15:0] lfsr_state;

    scrambler_lane_if lane_if ();

    scrambler_lane_ctrl dut (
        .pclk        (pclk),
        .reset       (reset),
        .scramble_en (scramble_en),
        .lane        (lane_if),
        .locked      (locked),
        .lfsr_state  (lfsr_state)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       k;
        logic       rdy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ok;
        logic       e_lk;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic k, input logic rdy,
                       input logic e_ir, input logic e_ov, input logic [7:0] e_od,
                       input logic e_ok, input logic e_lk);
        vec_t t;
        t = '{v, d, k, rdy, e_ir, e_ov, e_od, e_ok, e_lk};
        vq.push_back(t);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic k, input logic rdy);
        lane_if.in_valid  = v;
        lane_if.in_data   = d;
        lane_if.in_k      = k;
        lane_if.out_ready = rdy;
    endtask

    task automatic step_chk(input string tag, input logic v, input logic [7:0] d, input logic k,
                            input logic [7:0] e_od, input logic e_ok, input logic e_lk);
        drive(v, d, k, 1'b1);
        @(posedge pclk);
        #1;
        chk({tag, "_ov"}, 16'(lane_if.out_valid), 16'(1'b1));
        chk({tag, "_od"}, 16'(lane_if.out_data), 16'(e_od));
        chk({tag, "_ok"}, 16'(lane_if.out_k), 16'(e_ok));
        chk({tag, "_lk"}, 16'(locked), 16'(e_lk));
    endtask

    initial begin
        // idle in DIS moves to WAIT_COM
        add(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0);
        // COM then four D00
        add(1, 8'hBC, 1, 1, 1, 1, 8'hBC, 1, 1);
        add(1, 8'h00, 0, 1, 1, 1, 8'hFF, 0, 1);
        add(1, 8'h00, 0, 1, 1, 1, 8'h17, 0, 1);
        add(1, 8'h00, 0, 1, 1, 1, 8'hC0, 0, 1);
        add(1, 8'h00, 0, 1, 1, 1, 8'h14, 0, 1);
        // COM re-seeds, SKP holds
        add(1, 8'hBC, 1, 1, 1, 1, 8'hBC, 1, 1);
        add(1, 8'h00, 0, 1, 1, 1, 8'hFF, 0, 1);
        add(1, 8'h1C, 1, 1, 1, 1, 8'h1C, 1, 1);
        add(1, 8'h00, 0, 1, 1, 1, 8'h17, 0, 1);
        add(1, 8'hBC, 1, 1, 1, 1, 8'hBC, 1, 1);
        add(1, 8'h00, 0, 1, 1, 1, 8'hFF, 0, 1);
        add(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 1);
        // six D00 with a three-cycle stall
        add(1, 8'hBC, 1, 1, 1, 1, 8'hBC, 1, 1);
        add(1, 8'h00, 0, 1, 1, 1, 8'hFF, 0, 1);
        add(1, 8'h00, 0, 0, 0, 1, 8'hFF, 0, 1);
        add(1, 8'h00, 0, 0, 0, 1, 8'hFF, 0, 1);
        add(1, 8'h00, 0, 0, 0, 1, 8'hFF, 0, 1);
        add(1, 8'h00, 0, 1, 1, 1, 8'h17, 0, 1);
        add(1, 8'h00, 0, 1, 1, 1, 8'hC0, 0, 1);
        add(1, 8'h00, 0, 1, 1, 1, 8'h14, 0, 1);
        add(1, 8'h00, 0, 1, 1, 1, 8'hB2, 0, 1);
        add(1, 8'h00, 0, 1, 1, 1, 8'hE7, 0, 1);

        scramble_en = 1'b1;
        drive(0, 8'h00, 0, 1);
        reset = 1'b1;
        #12;
        chk("rst_ov", 16'(lane_if.out_valid), 16'(1'b0));
        chk("rst_lfsr", lfsr_state, 16'hFFFF);
        @(posedge pclk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_lk", 16'(locked), 16'(1'b0));
        chk("rst_od", 16'(lane_if.out_data), 16'h0000);

        foreach (vq[i]) begin
            drive(vq[i].v, vq[i].d, vq[i].k, vq[i].rdy);
            #1;
            chk($sformatf("v%0d_ir", i), 16'(lane_if.in_ready), 16'(vq[i].e_ir));
            @(posedge pclk);
            #1;
            chk($sformatf("v%0d_ov", i), 16'(lane_if.out_valid), 16'(vq[i].e_ov));
            chk($sformatf("v%0d_lk", i), 16'(locked), 16'(vq[i].e_lk));
            if (vq[i].e_ov) begin
                chk($sformatf("v%0d_od", i), 16'(lane_if.out_data), 16'(vq[i].e_od));
                chk($sformatf("v%0d_ok", i), 16'(lane_if.out_k), 16'(vq[i].e_ok));
            end
        end

        // disable mid-stream: bypass from that symbol on, LFSR seeded
        scramble_en = 1'b0;
        step_chk("dis0", 1, 8'h00, 0, 8'h00, 0, 0);
        chk("dis_lfsr", lfsr_state, 16'hFFFF);
        step_chk("dis1", 1, 8'h55, 0, 8'h55, 0, 0);
        scramble_en = 1'b1;
        step_chk("ren0", 1, 8'h00, 0, 8'h00, 0, 0);
        step_chk("ren1", 1, 8'h00, 0, 8'h00, 0, 0);
        step_chk("ren_com", 1, 8'hBC, 1, 8'hBC, 1, 1);
        step_chk("ren_d", 1, 8'h00, 0, 8'hFF, 0, 1);

        // reset while the output stage is stalled
        drive(1, 8'h00, 0, 0);
        @(posedge pclk);
        #1;
        chk("stall_ov", 16'(lane_if.out_valid), 16'(1'b1));
        chk("stall_od", 16'(lane_if.out_data), 16'h00FF);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_ov", 16'(lane_if.out_valid), 16'(1'b0));
        chk("mrst_od", 16'(lane_if.out_data), 16'h0000);
        chk("mrst_lk", 16'(locked), 16'(1'b0));
        chk("mrst_lfsr", lfsr_state, 16'hFFFF);
        @(posedge pclk);
        #1;
        reset = 1'b0;
        drive(0, 8'h00, 0, 1);
        @(posedge pclk);
        #1;
        chk("post_ov", 16'(lane_if.out_valid), 16'(1'b0));
        step_chk("post_com", 1, 8'hBC, 1, 8'hBC, 1, 1);
        step_chk("post_d", 1, 8'h00, 0, 8'hFF, 0, 1);
        step_chk("post_d2", 1, 8'h00, 0, 8'h17, 0, 1);

        drive(0, 8'h00, 0, 1);
        @(posedge pclk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
